// File: rtl/my_rx_uart.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, LSB-first reassembly,
// valid/ack delivery with one-cycle framing_error and overrun pulses.
module my_rx_uart #(
    parameter int unsigned SYSTEM_CLK_MHZ = 25,
    parameter int unsigned BAUDRATE       = 9600
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       valid,
    input  logic       ack,
    output logic       framing_error,
    output logic       overrun
);

    localparam int unsigned CLK_HZ            = SYSTEM_CLK_MHZ * 1000000;
    localparam int unsigned CYCLES_PER_SYMBOL = CLK_HZ / BAUDRATE;
    localparam int unsigned HALF_SYMBOL       = CYCLES_PER_SYMBOL >> 1;
    localparam int unsigned CW                = $clog2(CLK_HZ);

    localparam logic [CW-1:0] C_FULL = CW'(CYCLES_PER_SYMBOL);
    localparam logic [CW-1:0] C_HALF = CW'(HALF_SYMBOL);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DELIVER,
        BREAK_WAIT
    } state_t;

    state_t        r_state, w_state_n;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [2:0]    r_bit_idx, w_bit_idx_n;
    logic [7:0]    r_shift, w_shift_n;
    logic [7:0]    r_data, w_data_n;
    logic          r_valid, w_valid_n;
    logic          r_fe, w_fe_n;
    logic          r_ovr, w_ovr_n;
    logic          w_rx_s;
    logic          w_expired;

    assign w_rx_s    = r_sync[1];
    // Loaded with N, expiry lands on the N-th clock after the load.
    assign w_expired = (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync    <= '1;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_fe      <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx_in};
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_bit_idx <= w_bit_idx_n;
            r_shift   <= w_shift_n;
            r_data    <= w_data_n;
            r_valid   <= w_valid_n;
            r_fe      <= w_fe_n;
            r_ovr     <= w_ovr_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
        w_bit_idx_n = r_bit_idx;
        w_shift_n   = r_shift;
        w_data_n    = r_data;
        w_valid_n   = r_valid && !ack;
        w_fe_n      = 1'b0;
        w_ovr_n     = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_n   = C_HALF;
                    w_state_n = START;
                end
            end
            START: begin
                if (w_expired) begin
                    if (!w_rx_s) begin
                        w_cnt_n     = C_FULL;
                        w_bit_idx_n = '0;
                        w_state_n   = DATA;
                    end else begin
                        w_state_n   = IDLE;
                    end
                end
            end
            DATA: begin
                if (w_expired) begin
                    w_shift_n[r_bit_idx] = w_rx_s;
                    w_cnt_n              = C_FULL;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_n = '0;
                        w_state_n   = STOP;
                    end else begin
                        w_bit_idx_n = r_bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (w_expired) begin
                    if (w_rx_s) begin
                        w_state_n = DELIVER;
                    end else begin
                        w_fe_n    = 1'b1;
                        w_state_n = BREAK_WAIT;
                    end
                end
            end
            DELIVER: begin
                // An ack landing on this cycle consumes the old byte, so no overrun.
                w_data_n  = r_shift;
                w_valid_n = 1'b1;
                w_ovr_n   = r_valid && !ack;
                w_state_n = IDLE;
            end
            BREAK_WAIT: begin
                if (w_rx_s) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    assign rx_data       = r_data;
    assign valid         = r_valid;
    assign framing_error = r_fe;
    assign overrun       = r_ovr;

endmodule

// File: tb/tb_my_rx_uart.sv
// Self-checking bench for my_rx_uart at 10 clocks per bit: directed scenarios
// followed by random frames checked against a frame-level model.
module tb_my_rx_uart;

    localparam int unsigned MHZ  = 1;
    localparam int unsigned BAUD = 100000;
    localparam int CPS  = (MHZ * 1000000) / BAUD;
    localparam int HALF = CPS / 2;
    localparam int SYNC_READ = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       valid;
    logic       ack;
    logic       framing_error;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rise;
    int fe_cnt   = 0;
    int ovr_cnt  = 0;
    logic prev_valid = 1'b0;
    int frame_c0;

    my_rx_uart #(
        .SYSTEM_CLK_MHZ(MHZ),
        .BAUDRATE      (BAUD)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rx_in        (rx_in),
        .rx_data      (rx_data),
        .valid        (valid),
        .ack          (ack),
        .framing_error(framing_error),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid && !prev_valid) last_rise = cyc;
        prev_valid = valid;
        if (framing_error) fe_cnt++;
        if (overrun) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Start bit, 8 data bits LSB first, stop bit; each slot lasts CPS clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic ack_deliver);
        frame_c0  = cyc;
        last_rise = -1;
        rx_in = 1'b0;
        repeat (CPS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (CPS) @(negedge clk);
        end
        rx_in = stop_bit;
        for (int k = 0; k < CPS; k++) begin
            @(negedge clk);
            if (ack_deliver && k == CPS - 3) ack = 1'b1;
            if (ack_deliver && k == CPS - 2) ack = 1'b0;
        end
        rx_in = 1'b1;
        #1;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    function automatic int expected_rise(input int c0);
        return c0 + SYNC_READ + HALF + 9 * CPS + 1;
    endfunction

    task automatic check_rise(input string tag);
        int e;
        int d;
        e = expected_rise(frame_c0);
        d = last_rise - e;
        check(tag, (d >= -1 && d <= 1) ? e : last_rise, e);
    endtask

    initial begin
        int fe0;
        int ov0;
        logic [7:0] b;
        logic pending;
        logic [7:0] abort_byte;

        resetn = 1'b0;
        rx_in  = 1'b1;
        ack    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_fe", framing_error, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Two basic bytes with timing check, then single-cycle ack.
        send_frame(8'h55, 1'b1, 1'b0);
        check("b55_valid", valid, 1'b1);
        check("b55_data", rx_data, 8'h55);
        check_rise("b55_timing");
        ack_pulse();
        check("b55_ack_drop", valid, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0);
        check("bA3_valid", valid, 1'b1);
        check("bA3_data", rx_data, 8'hA3);
        check_rise("bA3_timing");
        ack_pulse();
        check("bA3_ack_drop", valid, 1'b0);

        // Ack while nothing is pending is ignored.
        ack_pulse();
        check("idle_ack_valid", valid, 1'b0);

        // Short low glitch is rejected.
        fe0 = fe_cnt;
        last_rise = -1;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_valid", valid, 1'b0);
        check("glitch_fe", fe_cnt - fe0, 0);
        send_frame(8'h0F, 1'b1, 1'b0);
        check("b0F_data", rx_data, 8'h0F);
        check("b0F_valid", valid, 1'b1);
        ack_pulse();

        // Low stop bit plus held-low line gives exactly one framing error.
        fe0 = fe_cnt;
        send_frame(8'h81, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (50) @(negedge clk);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        check("fe_once", fe_cnt - fe0, 1);
        check("fe_valid", valid, 1'b0);
        check("fe_data_kept", rx_data, 8'h0F);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("b3C_data", rx_data, 8'h3C);
        check("b3C_valid", valid, 1'b1);
        ack_pulse();

        // Back-to-back unacked bytes overrun.
        @(negedge clk);
        ov0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        check("b11_no_ovr", ovr_cnt - ov0, 0);
        check("b11_data", rx_data, 8'h11);
        send_frame(8'h22, 1'b1, 1'b0);
        check("b22_ovr", ovr_cnt - ov0, 1);
        check("b22_data", rx_data, 8'h22);
        check("b22_valid", valid, 1'b1);

        // Ack coinciding with delivery: new byte held, no overrun.
        ov0 = ovr_cnt;
        send_frame(8'h5A, 1'b1, 1'b1);
        check("ackdlv_valid", valid, 1'b1);
        check("ackdlv_data", rx_data, 8'h5A);
        check("ackdlv_no_ovr", ovr_cnt - ov0, 0);

        // Asynchronous reset in the middle of data bit 4.
        abort_byte = 8'hE6;
        rx_in = 1'b0;
        repeat (CPS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_in = abort_byte[i];
            repeat (CPS) @(negedge clk);
        end
        rx_in = abort_byte[4];
        repeat (CPS / 2) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_data", rx_data, 8'h00);
        check("arst_valid", valid, 1'b0);
        check("arst_fe", framing_error, 1'b0);
        check("arst_ovr", overrun, 1'b0);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'hC7, 1'b1, 1'b0);
        check("bC7_data", rx_data, 8'hC7);
        check("bC7_valid", valid, 1'b1);
        check_rise("bC7_timing");

        // Random frames against the pending-byte model.
        pending = 1'b1;
        for (int n = 0; n < 8; n++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            ov0 = ovr_cnt;
            send_frame(b, 1'b1, 1'b0);
            check("rnd_data", rx_data, b);
            check("rnd_valid", valid, 1'b1);
            check("rnd_ovr", ovr_cnt - ov0, pending ? 1 : 0);
            if ($urandom_range(0, 1) == 1) begin
                ack_pulse();
                check("rnd_ack_drop", valid, 1'b0);
                pending = 1'b0;
            end else begin
                pending = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
